// File: rtl/superscalar_processor.sv
// Dual-issue, in-order, single-cycle 32-bit core with unified instruction/data memory.
// Slot0 always issues; slot1 joins it only when it is independent and useful work.
module superscalar_processor #(
  parameter int MEM_DEPTH = 1024,
  parameter int NREG      = 32
) (
  input  logic clk1,
  input  logic reset
);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_MUL  = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b000011;
  localparam logic [5:0] OP_OR   = 6'b000100;
  localparam logic [5:0] OP_XOR  = 6'b000101;
  localparam logic [5:0] OP_SLL  = 6'b000110;
  localparam logic [5:0] OP_SRL  = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001001;
  localparam logic [5:0] OP_ANDI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001011;
  localparam logic [5:0] OP_XORI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b010000;
  localparam logic [5:0] OP_SW   = 6'b010001;
  localparam logic [5:0] OP_BEQ  = 6'b011000;
  localparam logic [5:0] OP_BNE  = 6'b011001;
  localparam logic [5:0] OP_BLT  = 6'b011010;
  localparam logic [5:0] OP_BGE  = 6'b011011;
  localparam logic [5:0] OP_J    = 6'b100000;
  localparam logic [5:0] OP_JAL  = 6'b100001;

  typedef struct packed {
    logic        valid;
    logic        is_ctrl;
    logic        is_mem;
    logic        rd_rs;
    logic        rd_rt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        reg_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;
    logic        mem_we;
    logic [9:0]  mem_wa;
    logic [31:0] mem_wd;
    logic        taken;
    logic [9:0]  target;
  } slot_t;

  logic [31:0] REG [0:NREG-1];
  logic [31:0] MEM [0:MEM_DEPTH-1];
  logic [9:0]  PC;

  logic [31:0] w_instr   [2];
  logic [9:0]  w_pc      [2];
  logic [31:0] w_rs_val  [2];
  logic [31:0] w_rt_val  [2];
  logic [9:0]  w_ea      [2];
  logic [31:0] w_ld_data [2];
  slot_t       w_slot    [2];

  logic        w_raw;
  logic        w_waw;
  logic        w_mem_pair;
  logic        w_ctrl;
  logic        w_dual;
  logic [9:0]  w_pc_next;

  // Fully decodes and evaluates one instruction against pre-cycle state.
  function automatic slot_t decode(
    input logic [31:0] instr,
    input logic [9:0]  pc,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] ld,
    input logic [9:0]  ea
  );
    slot_t       s;
    logic [31:0] sx;
    logic [31:0] zx;
    s        = '0;
    sx       = {{16{instr[15]}}, instr[15:0]};
    zx       = {16'd0, instr[15:0]};
    s.rs     = instr[25:21];
    s.rt     = instr[20:16];
    case (instr[31:26])
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
        s.valid  = 1'b1;
        s.rd_rs  = 1'b1;
        s.rd_rt  = 1'b1;
        s.reg_we = 1'b1;
        s.reg_wa = instr[15:11];
        case (instr[28:26])
          3'd0: s.reg_wd = a + b;
          3'd1: s.reg_wd = a - b;
          3'd2: s.reg_wd = a * b;
          3'd3: s.reg_wd = a & b;
          3'd4: s.reg_wd = a | b;
          3'd5: s.reg_wd = a ^ b;
          3'd6: s.reg_wd = a << b[4:0];
          3'd7: s.reg_wd = a >> b[4:0];
        endcase
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: begin
        s.valid  = 1'b1;
        s.rd_rs  = 1'b1;
        s.reg_we = 1'b1;
        s.reg_wa = instr[20:16];
        case (instr[31:26])
          OP_ADDI: s.reg_wd = a + sx;
          OP_SUBI: s.reg_wd = a - sx;
          OP_ANDI: s.reg_wd = a & zx;
          OP_ORI:  s.reg_wd = a | zx;
          default: s.reg_wd = a ^ zx;
        endcase
      end
      OP_LW: begin
        s.valid  = 1'b1;
        s.is_mem = 1'b1;
        s.rd_rs  = 1'b1;
        s.reg_we = 1'b1;
        s.reg_wa = instr[20:16];
        s.reg_wd = ld;
      end
      OP_SW: begin
        s.valid  = 1'b1;
        s.is_mem = 1'b1;
        s.rd_rs  = 1'b1;
        s.rd_rt  = 1'b1;
        s.mem_we = 1'b1;
        s.mem_wa = ea;
        s.mem_wd = b;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE: begin
        s.valid   = 1'b1;
        s.is_ctrl = 1'b1;
        s.rd_rs   = 1'b1;
        s.rd_rt   = 1'b1;
        // Low 10 bits of the sign-extended offset suffice for modulo-1024 targets.
        s.target  = pc + 10'd1 + instr[9:0];
        case (instr[31:26])
          OP_BEQ:  s.taken = (a == b);
          OP_BNE:  s.taken = (a != b);
          OP_BLT:  s.taken = ($signed(a) <  $signed(b));
          default: s.taken = ($signed(a) >= $signed(b));
        endcase
      end
      OP_J, OP_JAL: begin
        s.valid   = 1'b1;
        s.is_ctrl = 1'b1;
        s.taken   = 1'b1;
        s.target  = instr[9:0];
        if (instr[31:26] == OP_JAL) begin
          s.reg_we = 1'b1;
          s.reg_wa = 5'd31;
          s.reg_wd = {22'd0, pc + 10'd1};
        end
      end
      default: ;
    endcase
    s.reg_we = s.reg_we && (s.reg_wa != 5'd0);
    return s;
  endfunction

  assign w_pc[0] = PC;
  assign w_pc[1] = PC + 10'd1;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    assign w_instr[g]   = MEM[w_pc[g]];
    assign w_rs_val[g]  = (w_instr[g][25:21] == 5'd0) ? 32'd0 : REG[w_instr[g][25:21]];
    assign w_rt_val[g]  = (w_instr[g][20:16] == 5'd0) ? 32'd0 : REG[w_instr[g][20:16]];
    assign w_ea[g]      = w_rs_val[g][9:0] + w_instr[g][9:0];
    assign w_ld_data[g] = MEM[w_ea[g]];
    assign w_slot[g]    = decode(w_instr[g], w_pc[g], w_rs_val[g], w_rt_val[g],
                                 w_ld_data[g], w_ea[g]);
  end

  assign w_raw = w_slot[0].reg_we &&
                 ((w_slot[1].rd_rs && (w_slot[1].rs == w_slot[0].reg_wa)) ||
                  (w_slot[1].rd_rt && (w_slot[1].rt == w_slot[0].reg_wa)));
  assign w_waw = w_slot[0].reg_we && w_slot[1].reg_we &&
                 (w_slot[0].reg_wa == w_slot[1].reg_wa);
  assign w_mem_pair = w_slot[0].is_mem && w_slot[1].is_mem;
  assign w_ctrl     = w_slot[0].is_ctrl || w_slot[1].is_ctrl;

  // A NOP/undefined word in slot1 is left to be consumed as next cycle's slot0.
  assign w_dual = w_slot[1].valid && !w_raw && !w_waw && !w_mem_pair && !w_ctrl;

  assign w_pc_next = w_slot[0].taken ? w_slot[0].target :
                     w_dual          ? PC + 10'd2       :
                                       PC + 10'd1;

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      PC <= 10'd0;
    end else begin
      PC <= w_pc_next;
    end
  end

  // REG/MEM are never cleared, so preloads made while reset is low survive.
  always_ff @(posedge clk1) begin
    if (reset) begin
      if (w_slot[0].reg_we) begin
        REG[w_slot[0].reg_wa] <= w_slot[0].reg_wd;
      end
      if (w_dual && w_slot[1].reg_we) begin
        REG[w_slot[1].reg_wa] <= w_slot[1].reg_wd;
      end
      if (w_slot[0].mem_we) begin
        MEM[w_slot[0].mem_wa] <= w_slot[0].mem_wd;
      end else if (w_dual && w_slot[1].mem_we) begin
        MEM[w_slot[1].mem_wa] <= w_slot[1].mem_wd;
      end
    end
  end

endmodule

// File: tb/tb_superscalar_processor.sv
// Directed programs for superscalar_processor; expected architectural state is queued
// as each program is loaded and checked once the core has retired it.
module tb_superscalar_processor;

  localparam logic [5:0] ADD  = 6'b000000;
  localparam logic [5:0] MUL  = 6'b000010;
  localparam logic [5:0] SUB  = 6'b000001;
  localparam logic [5:0] SLL  = 6'b000110;
  localparam logic [5:0] SRL  = 6'b000111;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ORI  = 6'b001011;
  localparam logic [5:0] XORI = 6'b001100;
  localparam logic [5:0] LW   = 6'b010000;
  localparam logic [5:0] SW   = 6'b010001;
  localparam logic [5:0] BEQ  = 6'b011000;
  localparam logic [5:0] BNE  = 6'b011001;
  localparam logic [5:0] BLT  = 6'b011010;
  localparam logic [5:0] BGE  = 6'b011011;
  localparam logic [5:0] J    = 6'b100000;
  localparam logic [5:0] JAL  = 6'b100001;
  localparam logic [31:0] NOP = 32'hFC00_0000;

  localparam int K_REG = 0;
  localparam int K_MEM = 1;
  localparam int K_PC  = 2;

  logic clk1  = 1'b0;
  logic reset = 1'b0;

  superscalar_processor dut (
    .clk1  (clk1),
    .reset (reset)
  );

  always #5 clk1 = ~clk1;

  string       q_tag  [$];
  int          q_kind [$];
  int          q_idx  [$];
  logic [31:0] q_exp  [$];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  function automatic logic [31:0] enc_r(logic [5:0] op, int rs, int rt, int rd);
    return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, int tgt);
    return {op, tgt[25:0]};
  endfunction

  task automatic expect_state(string tag, int kind, int idx, logic [31:0] exp);
    q_tag.push_back(tag);
    q_kind.push_back(kind);
    q_idx.push_back(idx);
    q_exp.push_back(exp);
  endtask

  function automatic logic [31:0] observe(int kind, int idx);
    case (kind)
      K_REG:   return dut.REG[5'(idx)];
      K_MEM:   return dut.MEM[10'(idx)];
      default: return {22'd0, dut.PC};
    endcase
  endfunction

  task automatic drain();
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
    logic [31:0] act;
    while (q_tag.size() > 0) begin
      tag  = q_tag.pop_front();
      kind = q_kind.pop_front();
      idx  = q_idx.pop_front();
      exp  = q_exp.pop_front();
      act  = observe(kind, idx);
      n_total++;
      assert (act === exp) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
    end
  endtask

  // Holds the core in reset and wipes REG/MEM to a known state.
  task automatic begin_program();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) dut.REG[5'(i)] = 32'd0;
    for (int i = 0; i < 1024; i++) dut.MEM[10'(i)] = NOP;
  endtask

  task automatic release_reset();
    @(negedge clk1);
    reset = 1'b1;
  endtask

  task automatic run(int edges);
    repeat (edges) @(negedge clk1);
  endtask

  initial begin
    // Load/store: memory pairs never dual-issue
    begin_program();
    dut.MEM[50] = 32'd100;
    dut.MEM[40] = 32'd200;
    dut.MEM[80] = 32'd300;
    dut.MEM[0]  = enc_i(LW, 0, 1, 50);
    dut.MEM[1]  = enc_i(LW, 0, 2, 40);
    dut.MEM[2]  = enc_i(LW, 0, 3, 80);
    dut.MEM[3]  = enc_i(SW, 0, 1, 15);
    dut.MEM[4]  = enc_i(SW, 0, 2, 16);
    dut.MEM[5]  = enc_i(SW, 0, 3, 17);
    expect_state("reset_pc", K_PC, 0, 32'd0);
    drain();
    release_reset();
    expect_state("ls_r1", K_REG, 1, 32'd100);
    expect_state("ls_r2", K_REG, 2, 32'd200);
    expect_state("ls_r3", K_REG, 3, 32'd300);
    expect_state("ls_m15", K_MEM, 15, 32'd100);
    expect_state("ls_m16", K_MEM, 16, 32'd200);
    expect_state("ls_m17", K_MEM, 17, 32'd300);
    expect_state("ls_pc", K_PC, 0, 32'd6);
    run(6);
    drain();

    // Dual issue of independent ALU ops
    begin_program();
    dut.MEM[0] = enc_i(ADDI, 0, 1, 5);
    dut.MEM[1] = enc_i(ADDI, 0, 2, -3);
    release_reset();
    expect_state("dual_r1", K_REG, 1, 32'd5);
    expect_state("dual_r2", K_REG, 2, 32'hFFFF_FFFD);
    expect_state("dual_pc", K_PC, 0, 32'd2);
    run(1);
    drain();

    // RAW hazard splits the pair
    begin_program();
    dut.MEM[0] = enc_i(ADDI, 0, 1, 6);
    dut.MEM[1] = enc_r(MUL, 1, 1, 3);
    release_reset();
    expect_state("raw_pc1", K_PC, 0, 32'd1);
    expect_state("raw_r1", K_REG, 1, 32'd6);
    expect_state("raw_r3_early", K_REG, 3, 32'd0);
    run(1);
    drain();
    expect_state("raw_pc2", K_PC, 0, 32'd2);
    expect_state("raw_r3", K_REG, 3, 32'd36);
    run(1);
    drain();

    // Taken BEQ skips two instructions
    begin_program();
    dut.MEM[0] = enc_i(ADDI, 0, 1, 4);
    dut.MEM[1] = enc_i(ADDI, 0, 2, 4);
    dut.MEM[2] = enc_i(BEQ, 1, 2, 2);
    dut.MEM[3] = enc_i(ADDI, 0, 5, 1);
    dut.MEM[4] = enc_i(ADDI, 0, 6, 1);
    dut.MEM[5] = enc_i(ADDI, 0, 7, 9);
    release_reset();
    expect_state("beq_r5", K_REG, 5, 32'd0);
    expect_state("beq_r6", K_REG, 6, 32'd0);
    expect_state("beq_r7", K_REG, 7, 32'd9);
    expect_state("beq_pc", K_PC, 0, 32'd6);
    run(3);
    drain();

    // Signed BLT taken, BGE with negative offset not taken, BNE taken
    begin_program();
    dut.MEM[0] = enc_i(ADDI, 0, 1, -1);
    dut.MEM[1] = enc_i(ADDI, 0, 2, 1);
    dut.MEM[2] = enc_i(BLT, 1, 2, 3);
    dut.MEM[3] = enc_i(ADDI, 0, 5, 1);
    dut.MEM[4] = enc_i(ADDI, 0, 5, 1);
    dut.MEM[5] = enc_i(ADDI, 0, 5, 1);
    dut.MEM[6] = enc_i(BGE, 1, 2, -6);
    dut.MEM[7] = enc_i(BNE, 1, 2, 1);
    dut.MEM[8] = enc_i(ADDI, 0, 5, 1);
    dut.MEM[9] = enc_i(ADDI, 0, 8, 8);
    release_reset();
    expect_state("br_pc", K_PC, 0, 32'd10);
    expect_state("br_r8", K_REG, 8, 32'd8);
    expect_state("br_r5", K_REG, 5, 32'd0);
    run(5);
    drain();

    // J then JAL links the return address
    begin_program();
    dut.MEM[0]  = enc_j(J, 10);
    dut.MEM[10] = enc_j(JAL, 20);
    release_reset();
    expect_state("j_pc", K_PC, 0, 32'd10);
    run(1);
    drain();
    expect_state("jal_r31", K_REG, 31, 32'd11);
    expect_state("jal_pc", K_PC, 0, 32'd20);
    run(1);
    drain();

    // R0 discard, zero-extended immediates, shifts
    begin_program();
    dut.MEM[0] = enc_i(ADDI, 0, 0, 7);
    dut.MEM[1] = enc_i(ORI, 0, 4, 16'h8000);
    dut.MEM[2] = enc_i(ORI, 0, 8, 1);
    dut.MEM[3] = enc_i(ORI, 0, 9, 31);
    dut.MEM[4] = enc_r(SLL, 8, 9, 10);
    dut.MEM[5] = enc_r(SRL, 10, 9, 11);
    dut.MEM[6] = enc_r(SUB, 4, 9, 12);
    dut.MEM[7] = enc_i(XORI, 0, 13, 16'hFFFF);
    dut.MEM[8] = enc_r(ADD, 12, 13, 14);
    release_reset();
    expect_state("r0_zero", K_REG, 0, 32'd0);
    expect_state("ori_r4", K_REG, 4, 32'h0000_8000);
    expect_state("sll_r10", K_REG, 10, 32'h8000_0000);
    expect_state("srl_r11", K_REG, 11, 32'd1);
    expect_state("sub_r12", K_REG, 12, 32'h0000_7FE1);
    expect_state("xori_r13", K_REG, 13, 32'h0000_FFFF);
    expect_state("add_r14", K_REG, 14, 32'h0001_7FE0);
    expect_state("logic_pc", K_PC, 0, 32'd9);
    run(6);
    drain();

    // Mid-run reset: PC clears at once, no writes while held
    begin_program();
    dut.MEM[50] = 32'd100;
    dut.MEM[40] = 32'd200;
    dut.MEM[80] = 32'd300;
    dut.MEM[0]  = enc_i(LW, 0, 1, 50);
    dut.MEM[1]  = enc_i(LW, 0, 2, 40);
    dut.MEM[2]  = enc_i(LW, 0, 3, 80);
    dut.MEM[3]  = enc_i(SW, 0, 1, 15);
    dut.MEM[4]  = enc_i(SW, 0, 2, 16);
    dut.MEM[5]  = enc_i(SW, 0, 3, 17);
    release_reset();
    run(3);
    #1 reset = 1'b0;
    #1;
    expect_state("rst_pc_async", K_PC, 0, 32'd0);
    expect_state("rst_r1_kept", K_REG, 1, 32'd100);
    expect_state("rst_m15_kept", K_MEM, 15, NOP);
    drain();
    dut.MEM[50] = 32'd555;
    run(2);
    expect_state("rst_pc_held", K_PC, 0, 32'd0);
    expect_state("rst_r1_nowrite", K_REG, 1, 32'd100);
    expect_state("rst_m15_nowrite", K_MEM, 15, NOP);
    drain();
    release_reset();
    expect_state("rst_r1_rerun", K_REG, 1, 32'd555);
    expect_state("rst_m15_rerun", K_MEM, 15, 32'd555);
    expect_state("rst_pc_rerun", K_PC, 0, 32'd6);
    run(6);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/superscalar_processor.md
# superscalar_processor

Dual-issue, in-order, 32-bit processor core. It fetches up to two instructions per clock from a unified instruction/data memory, executes them, and retires them in the same cycle. It is the top of the processor; all architectural state (register file, memory, PC) lives inside it. Benches preload and inspect the register file and memory hierarchically.

## Interface
- `MEM_DEPTH`, default 1024: number of 32-bit words in the unified memory; the address is its low 10 bits.
- `NREG`, default 32: number of 32-bit general registers.
- `clk1`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low. While low, PC = 0 and no instruction retires.
- No other ports.
- Required internal names:
  - `REG[0:31]` (32-bit): register file.
  - `MEM[0:1023]` (32-bit): unified memory.
  - `PC` (10-bit): word address.

## Operation
- Instruction fields:
  - opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm16 [15:0], target [25:0].
- R-type (rd ← rs op rt): ADD 000000, SUB 000001, MUL 000010 (low 32 bits), AND 000011, OR 000100, XOR 000101, SLL 000110, SRL 000111 (logical).
  - Shift amount is rt[4:0].
- I-type (rt ← rs op imm):
  - ADDI 001000 and SUBI 001001 sign-extend imm16.
  - ANDI 001010, ORI 001011, XORI 001100 zero-extend imm16.
- Memory:
  - LW 010000: rt ← MEM[(rs + sext(imm16))[9:0]].
  - SW 010001: MEM[(rs + sext(imm16))[9:0]] ← rt.
- Branches (compare rs with rt, signed for BLT/BGE): BEQ 011000, BNE 011001, BLT 011010, BGE 011011.
  - Taken target = branch PC + 1 + sext(imm16), modulo 1024.
- Jumps:
  - J 100000: PC ← target[9:0].
  - JAL 100001: R31 ← branch PC + 1, and PC ← target[9:0].
- NOP 111111, and any undefined opcode: no state change.
- R0 reads as 0 always; writes to R0 are discarded.
- Fetch: slot0 = MEM[PC], slot1 = MEM[PC+1] (wraps 1023→0).
- Slot1 issues together with slot0 unless any of the following holds; then slot0 issues alone and PC += 1:
  - slot1 reads a register that slot0 writes (RAW);
  - both slots write the same nonzero register;
  - both slots are LW/SW (single data port);
  - either slot is a branch or jump (control instructions always issue alone, in slot0).
- Otherwise both issue and PC += 2 (modulo 1024). Register and memory reads see state from before the cycle.
- A taken branch or jump overrides the PC increment.
- Reset clears only the PC. REG and MEM are not cleared, so preloads written during reset survive.

## Timing
- Single-cycle execution; no pipeline, so no forwarding is needed.
- Each rising clock edge with reset high retires 1 or 2 instructions: register writes, memory write and PC update all occur at that edge.
- Memory and register reads are combinational.
- First retirement is at the first rising edge after reset goes high, executing from PC 0.
- Reset asserted mid-run: PC returns to 0 immediately (asynchronous). No REG/MEM write occurs while reset is low. Execution resumes from 0.
- PC wraps at 1023→0.
- Addresses ≥ 1024 cannot occur; effective addresses are truncated to 10 bits.

## Test plan
- **Load/store:**
  - Preload MEM[50]=100, MEM[40]=200, MEM[80]=300.
  - Program (MEM[6..] = NOP): 0: LW R1,50(R0); 1: LW R2,40(R0); 2: LW R3,80(R0); 3: SW R1,15(R0); 4: SW R2,16(R0); 5: SW R3,17(R0).
  - Required: one instruction per cycle. After 6 edges, R1=100, R2=200, R3=300, MEM[15]=100, MEM[16]=200, MEM[17]=300, PC=6.
- **Dual issue:** ADDI R1,R0,5 ; ADDI R2,R0,-3. After one edge, R1=5, R2=0xFFFFFFFD, PC=2.
- **RAW split:** ADDI R1,R0,6 ; MUL R3,R1,R1. Needs two edges, PC 0→1→2. R3=36.
- **Branch:**
  - Program: R1=R2=4; BEQ R1,R2,+2; ADDI R5,R0,1; ADDI R6,R0,1; ADDI R7,R0,9.
  - R5 and R6 stay 0; R7=9.
  - JAL at PC 10, target 20: R31=11, PC=20.
- **R0 and logic:** ADDI R0,R0,7 leaves R0=0. ORI R4,R0,0x8000 gives R4=0x00008000. SRL of 0x80000000 by 31 gives 1.
- **Reset:** drive reset low mid-program. PC reads 0 with no clock edge, REG/MEM are unchanged, and execution restarts at 0 after release.
